// File: rtl/mod_counter_ctrl_pkg.sv
// Shared types and default widths for the mod-M run controller.
package mod_ctrl_pkg;

    localparam int N_DEF = 4;
    localparam int C_DEF = 8;

    // Encoding 2'd3 is unused; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mod_counter_ctrl_if.sv
// Control/status bundle between the host and the mod-M run controller.
interface mod_counter_ctrl_if
    import mod_ctrl_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int C = C_DEF
);
    logic         start;
    logic         stop;
    logic [N-1:0] mod_val;
    logic [C-1:0] rep_cnt;
    logic [N-1:0] q;
    logic         tick;
    logic         busy;
    logic         done;
    logic         err;

    modport master (output start, stop, mod_val, rep_cnt,
                    input  q, tick, busy, done, err);
    modport slave  (input  start, stop, mod_val, rep_cnt,
                    output q, tick, busy, done, err);
endinterface

// File: rtl/mod_counter_ctrl_prog_mod_counter.sv
// Programmable mod-M counter; wrap flags the terminal value mod-1.
module prog_mod_counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [N-1:0] mod,
    output logic [N-1:0] q,
    output logic         wrap
);
    logic [N-1:0] q_q;

    assign q    = q_q;
    assign wrap = (q_q == mod - N'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q_q <= '0;
        else if (clr)
            q_q <= '0;
        else if (en)
            q_q <= wrap ? '0 : q_q + N'(1);
    end
endmodule

// File: rtl/mod_counter_ctrl.sv
// Start/stop/done run controller: counts mod_r for exactly rep_r full wraps.
module mod_counter_ctrl
    import mod_ctrl_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int C = C_DEF
) (
    input  logic              clk,
    input  logic              reset,
    mod_counter_ctrl_if.slave bus
);
    state_e       state_q;
    logic [N-1:0] mod_q;
    logic [C-1:0] rep_q;
    logic [C-1:0] wrap_q;
    logic         done_q;
    logic         err_q;

    logic         run;
    logic         tc;
    logic         cfg_ok;
    logic [N-1:0] cnt_q;

    assign run    = (state_q == ST_RUN);
    assign cfg_ok = (bus.mod_val >= N'(2)) && (bus.rep_cnt != '0);

    // Counter is held clear outside RUN and on an abort, so q reads 0 in IDLE/DONE.
    prog_mod_counter #(.N(N)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (run),
        .clr   (!run || bus.stop),
        .mod   (mod_q),
        .q     (cnt_q),
        .wrap  (tc)
    );

    assign bus.q    = cnt_q;
    assign bus.busy = run;
    assign bus.tick = run && tc;
    assign bus.done = done_q;
    assign bus.err  = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mod_q   <= '0;
            rep_q   <= '0;
            wrap_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        if (cfg_ok) begin
                            mod_q   <= bus.mod_val;
                            rep_q   <= bus.rep_cnt;
                            wrap_q  <= '0;
                            state_q <= ST_RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Abort beats completion in the same cycle.
                    if (bus.stop) begin
                        wrap_q  <= '0;
                        state_q <= ST_IDLE;
                    end else if (tc) begin
                        if (wrap_q == rep_q - C'(1)) begin
                            wrap_q  <= '0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            wrap_q <= wrap_q + C'(1);
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Directed bench for mod_counter_ctrl: vector table plus multi-cycle corner sequences.
module tb_mod_counter_ctrl;
    import mod_ctrl_pkg::*;

    localparam int N = 4;
    localparam int C = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    mod_counter_ctrl_if #(.N(N), .C(C)) bus ();

    mod_counter_ctrl #(.N(N), .C(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         start;
        logic         stop;
        logic [N-1:0] mod_val;
        logic [C-1:0] rep_cnt;
        logic [N-1:0] q;
        logic         tick;
        logic         busy;
        logic         done;
        logic         err;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [N-1:0] q, input logic tick,
                           input logic busy, input logic done, input logic err);
        chk({name, ".q"},    32'(bus.q),    32'(q));
        chk({name, ".tick"}, 32'(bus.tick), 32'(tick));
        chk({name, ".busy"}, 32'(bus.busy), 32'(busy));
        chk({name, ".done"}, 32'(bus.done), 32'(done));
        chk({name, ".err"},  32'(bus.err),  32'(err));
    endtask

    task automatic add(input logic st, input logic sp, input int m, input int r,
                       input int q, input logic tk, input logic bz, input logic dn, input logic er);
        vec_t v;
        v.start = st; v.stop = sp; v.mod_val = N'(m); v.rep_cnt = C'(r);
        v.q = N'(q); v.tick = tk; v.busy = bz; v.done = dn; v.err = er;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic st, input logic sp, input int m, input int r);
        bus.start = st; bus.stop = sp; bus.mod_val = N'(m); bus.rep_cnt = C'(r);
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ticks;
        drive(0, 0, 0, 0);

        // Async reset must clear outputs before any clock edge.
        #3 reset = 1'b1;
        #1 chk_all("reset", 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        step();
        chk_all("post_reset", 0, 0, 0, 0, 0);

        // mod 10, one wrap
        add(1, 0, 10, 1, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 9; k++) add(0, 0, 10, 1, k, k == 9, 1, 0, 0);
        add(0, 0, 10, 1, 0, 0, 0, 1, 0);
        add(0, 0, 10, 1, 0, 0, 0, 0, 0);
        // invalid configurations and start+stop
        add(1, 0, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 5, 0, 0, 0, 0, 0, 1);
        add(0, 0, 5, 0, 0, 0, 0, 0, 0);
        add(1, 1, 5, 1, 0, 0, 0, 0, 0);
        add(0, 0, 5, 1, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].stop, int'(vecs[i].mod_val), int'(vecs[i].rep_cnt));
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].tick, vecs[i].busy,
                    vecs[i].done, vecs[i].err);
        end

        // mod 3 x 2 wraps; mod_val change mid-run must be ignored.
        drive(1, 0, 3, 2);
        step();
        chk_all("m3_start", 0, 0, 1, 0, 0);
        drive(0, 0, 5, 2);
        ticks = 0;
        for (int k = 1; k < 6; k++) begin
            step();
            if (bus.tick) ticks++;
            chk_all($sformatf("m3_c%0d", k), N'(k % 3), (k % 3) == 2, 1, 0, 0);
        end
        step();
        chk_all("m3_done", 0, 0, 0, 1, 0);
        chk("m3_ticks", 32'(ticks), 32'd2);
        step();
        chk_all("m3_idle", 0, 0, 0, 0, 0);

        // mod 4 x 3, abort at wrap=1, q=2.
        drive(1, 0, 4, 3);
        step();
        drive(0, 0, 4, 3);
        for (int k = 1; k <= 6; k++) step();
        chk_all("m4_pre_stop", 2, 0, 1, 0, 0);
        drive(0, 1, 4, 3);
        step();
        chk_all("m4_stop", 0, 0, 0, 0, 0);
        drive(0, 0, 4, 3);
        step();
        chk_all("m4_after", 0, 0, 0, 0, 0);
        drive(1, 0, 4, 1);
        step();
        chk_all("m4_restart", 0, 0, 1, 0, 0);
        drive(0, 0, 4, 1);
        for (int k = 1; k <= 3; k++) step();
        chk_all("m4_tc", 3, 1, 1, 0, 0);
        step();
        chk_all("m4_done", 0, 0, 0, 1, 0);
        step();

        // Async reset mid-run at q=6.
        drive(1, 0, 10, 1);
        step();
        drive(0, 0, 10, 1);
        for (int k = 1; k <= 6; k++) step();
        chk_all("rst_pre", 6, 0, 1, 0, 0);
        #1 reset = 1'b1;
        #1 chk_all("rst_mid", 0, 0, 0, 0, 0);
        #1 reset = 1'b0;
        step();
        chk_all("rst_after", 0, 0, 0, 0, 0);

        // start held through DONE: ignored there, accepted once back in IDLE.
        drive(1, 0, 2, 1);
        step();
        chk_all("hold_start", 0, 0, 1, 0, 0);
        step();
        chk_all("hold_tc", 1, 1, 1, 0, 0);
        step();
        chk_all("hold_done", 0, 0, 0, 1, 0);
        step();
        chk_all("hold_idle", 0, 0, 0, 0, 0);
        step();
        chk_all("hold_rerun", 0, 0, 1, 0, 0);
        drive(0, 0, 2, 1);
        step();
        step();
        chk_all("hold_done2", 0, 0, 0, 1, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
